// File: rtl/hazard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_pkg : shared types and helpers for the pipeline hazard controller
// Rev 1.0
// ----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  localparam logic [1:0] WSEL_LOAD_DEF = 2'b01;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic       ld;
  } trk_entry_t;

  localparam trk_entry_t TRK_EMPTY = '{v: 1'b0, we: 1'b0, rd: 5'd0, ld: 1'b0};

  // x0 is hard-wired zero, so it can never be a real dependency.
  function automatic logic trk_match(input trk_entry_t t, input logic [4:0] rs,
                                     input logic used, input logic id_valid);
    return t.v & t.we & (t.rd == rs) & (rs != 5'd0) & used & id_valid;
  endfunction

  // Youngest producer wins; a load still in EX has no data yet, so no EX forward.
  function automatic logic [1:0] fwd_pick(input logic m_ex, input logic m_mem,
                                          input logic m_wb, input logic ex_ld);
    if (m_ex)  return ex_ld ? FWD_RF : FWD_EX;
    if (m_mem) return FWD_MEM;
    if (m_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_track.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_track : 3-entry shadow of ID/EX, EX/MEM, MEM/WB destination info
// Rev 1.0
// ----------------------------------------------------------------------------
module hazard_track
  import hazard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bubble_i,
  input  trk_entry_t id_entry_i,
  output trk_entry_t t_ex_o,
  output trk_entry_t t_mem_o,
  output trk_entry_t t_wb_o
);

  trk_entry_t ex_q, mem_q, wb_q;
  trk_entry_t ex_d;

  always_comb begin
    ex_d = id_entry_i;
    if (bubble_i) ex_d = TRK_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= TRK_EMPTY;
      mem_q <= TRK_EMPTY;
      wb_q  <= TRK_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign t_ex_o  = ex_q;
  assign t_mem_o = mem_q;
  assign t_wb_o  = wb_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_ctrl : stall / flush / operand-forward control for the 5-stage core
// Rev 1.0
// ----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter bit          FWD_EN    = 1'b1,
  parameter logic [1:0]  WSEL_LOAD = WSEL_LOAD_DEF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             id_rf_we_i,
  input  logic [4:0]       id_rd_i,
  input  logic [1:0]       id_rf_wsel_i,
  input  logic             ex_redirect_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  trk_entry_t w_id_entry, w_t_ex, w_t_mem, w_t_wb;
  logic       w_m1_ex, w_m1_mem, w_m1_wb;
  logic       w_m2_ex, w_m2_mem, w_m2_wb;
  logic       w_stall;
  logic       w_idex_flush;
  logic       w_unused;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign w_id_entry = '{v:  id_valid_i,
                        we: id_rf_we_i,
                        rd: id_rd_i,
                        ld: (id_rf_wsel_i == WSEL_LOAD)};

  // A stalled or redirected ID instruction must not be recorded as issued.
  assign w_idex_flush = w_stall | ex_redirect_i;

  hazard_track u_track (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bubble_i   (w_idex_flush),
    .id_entry_i (w_id_entry),
    .t_ex_o     (w_t_ex),
    .t_mem_o    (w_t_mem),
    .t_wb_o     (w_t_wb)
  );

  assign w_m1_ex  = trk_match(w_t_ex,  id_rs1_i, id_rs1_used_i, id_valid_i);
  assign w_m1_mem = trk_match(w_t_mem, id_rs1_i, id_rs1_used_i, id_valid_i);
  assign w_m1_wb  = trk_match(w_t_wb,  id_rs1_i, id_rs1_used_i, id_valid_i);
  assign w_m2_ex  = trk_match(w_t_ex,  id_rs2_i, id_rs2_used_i, id_valid_i);
  assign w_m2_mem = trk_match(w_t_mem, id_rs2_i, id_rs2_used_i, id_valid_i);
  assign w_m2_wb  = trk_match(w_t_wb,  id_rs2_i, id_rs2_used_i, id_valid_i);

  generate
    if (FWD_EN) begin : g_fwd
      assign w_stall = w_t_ex.ld & (w_m1_ex | w_m2_ex);
      assign fwd_a_o = fwd_pick(w_m1_ex, w_m1_mem, w_m1_wb, w_t_ex.ld);
      assign fwd_b_o = fwd_pick(w_m2_ex, w_m2_mem, w_m2_wb, w_t_ex.ld);
    end else begin : g_stall_only
      logic w_unused_ex_ld;
      // Without a bypass network, wait until the producer has written back.
      assign w_stall = w_m1_ex | w_m1_mem | w_m1_wb | w_m2_ex | w_m2_mem | w_m2_wb;
      assign fwd_a_o = FWD_RF;
      assign fwd_b_o = FWD_RF;
      assign w_unused_ex_ld = w_t_ex.ld;
    end
  endgenerate

  // Redirect wins: the stalled instruction is on the wrong path anyway.
  assign pc_stall_o   = w_stall & ~ex_redirect_i;
  assign ifid_stall_o = w_stall & ~ex_redirect_i;
  assign ifid_flush_o = ex_redirect_i;
  assign idex_flush_o = w_idex_flush;

  always_comb begin
    cnt_d = cnt_q;
    if (w_stall && !ex_redirect_i && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;
  assign w_unused    = ^{w_t_mem.ld, w_t_wb.ld};

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It shadows the destination-register information of the instructions held in the ID/EX, EX/MEM and MEM/WB pipeline registers in its own tracking pipeline. From that it drives stall, flush and operand-forwarding controls to the PC, IF/ID and ID/EX registers. It sits beside the decode stage and is the only block allowed to hold or bubble the front-end pipeline registers.

## Interface
Parameters:
- FWD_EN, 1: 1 selects forwarding with load-use stall only; 0 stalls on every RAW hazard until the producer has left WB.
- WSEL_LOAD, 2'b01: rf_wsel encoding meaning "write-back data from RAM" (load).
- CNT_W, 32: width of the stall performance counter.

Ports (reset rst_i, asynchronous, active-high; clock clk_i):
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i / id_rs2_i  in  5  source register numbers
- id_rs1_used_i / id_rs2_used_i  in  1  source operand actually read
- id_rf_we_i  in  1  instruction in ID writes the register file
- id_rd_i  in  5  destination register
- id_rf_wsel_i  in  2  write-back select of instruction in ID
- ex_redirect_i  in  1  EX resolved a taken branch/jump this cycle
- pc_stall_o  out  1  hold PC
- ifid_stall_o  out  1  hold IF/ID register
- ifid_flush_o  out  1  clear IF/ID register
- idex_flush_o  out  1  load a bubble into ID/EX (npc_op, ram_we, rf_we = 0)
- fwd_a_o / fwd_b_o  out  2  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB data
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Tracking pipeline: three entries, T_EX, T_MEM and T_WB. Each entry is {v, we, rd, ld}, where ld = (rf_wsel == WSEL_LOAD).
- Each clock: T_WB<=T_MEM and T_MEM<=T_EX.
  - T_EX<=ID record when ID advances.
  - T_EX<=invalid entry when idex_flush_o is 1.
- Match(rs, T): T.v & T.we & (T.rd == rs) & (rs != 0) & rs_used & id_valid_i. x0 never matches.
- When FWD_EN=1:
  - load_use = Match(rs1 or rs2, T_EX) & T_EX.ld.
  - Forward select priority is T_EX(01) > T_MEM(10) > T_WB(11) > 00.
  - A match on a load in T_EX never forwards 01; the block stalls instead.
- When FWD_EN=0:
  - hazard = any Match against T_EX, T_MEM or T_WB.
  - fwd_*_o are held at 00.
- stall = load_use (or hazard). On stall: pc_stall_o=1, ifid_stall_o=1, idex_flush_o=1.
- ex_redirect_i=1: ifid_flush_o=1, idex_flush_o=1, pc_stall_o=0, ifid_stall_o=0.
  - Redirect overrides stall in the same cycle, because the stalled instruction is on the wrong path.
- stall_cnt_o increments in every cycle where stall=1 and ex_redirect_i=0. It saturates at all-ones.
- Reset:
  - All tracking entries become invalid and stall_cnt_o becomes 0.
  - All outputs read 0 (fwd 00), since they are derived from empty tracking.
  - Reset asserted mid-stall aborts the stall immediately. No partial state survives.

## Timing
- All hazard outputs are combinational from the tracking registers and the ID inputs, and are valid in the same cycle. There is no registered output except stall_cnt_o.
- Load-use:
  - Cycle N: load in T_EX, dependent in ID, so stall=1.
  - Cycle N+1: load in T_MEM, bubble in T_EX, stall=0, fwd=10.
  - Stall lasts exactly 1 cycle.
- FWD_EN=0: a dependent that immediately follows its producer stalls 3 cycles. It proceeds in the cycle where the producer has left T_WB. The regfile is write-before-read.
- Redirect: flush is asserted in the same cycle as ex_redirect_i. Two wrong-path slots are squashed and there is no stall cycle.
- Simultaneous matches in several stages: the youngest (EX) wins.
- rs1 and rs2 are resolved independently.

## Structure
- Shared package hazard_pkg contains:
  - fwd encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB
  - the trk_entry_t struct {v, we, rd, ld}
  - the WSEL_LOAD default
- One sub-module is natural: hazard_track, a 3-entry shift register of trk_entry_t with bubble insert. The match and priority logic stays in hazard_ctrl.

## Test plan
- Back-to-back ALU RAW: add x5 then sub x6,x5,x7 (FWD_EN=1) -> no stall, fwd_a_o=01 in the sub's ID cycle, then its value moves through the stages.
- Load-use: lw x5 then add x6,x5,x5 -> cycle N: pc_stall_o=ifid_stall_o=idex_flush_o=1 and stall_cnt_o increments to 1; cycle N+1: no stall, fwd_a_o=fwd_b_o=10.
- x0 and unused operand: producer writes x0 and consumer reads x0 -> fwd 00, no stall; rs2_used_i=0 with a matching rd -> fwd_b_o=00.
- Priority: x5 written in T_WB, T_MEM and T_EX simultaneously -> fwd_a_o=01; remove the T_EX writer -> 10.
- Redirect during load-use stall: ex_redirect_i=1 in the stall cycle -> ifid_flush_o=idex_flush_o=1, pc_stall_o=0, stall_cnt_o unchanged.
- FWD_EN=0 plus reset: a dependent one cycle behind its producer stalls 3 cycles (stall_cnt_o=3). Asserting rst_i during the 2nd stall cycle -> all outputs 0 asynchronously and stall_cnt_o=0.
